uart_inst_loader: RTL



---
 rtl/uart_inst_loader_pkg.sv | 20 ++
 rtl/uart_inst_loader_rx_byte.sv | 107 ++++++++++
 rtl/uart_inst_loader.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/uart_inst_loader_pkg.sv
// Shared constants for the UART instruction loader: defaults, header byte and
// FSM state encodings for the loader and the byte receiver.
package uart_inst_loader_pkg;

    localparam int         BAUD_DIV_DEF = 434;
    localparam int         IADR_W_DEF   = 12;
    localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN0  = 3'd1;
    localparam logic [2:0] ST_LEN1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_START = 3'd4;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_inst_loader_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, single-cycle
// byte_valid / frame_err pulses. There is no backpressure on either pulse.
module uart_rx_byte
    import uart_inst_loader_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o,
    output logic [1:0] dbg_state_o
);

    localparam int             CW      = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]  HALF_M1 = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(BAUD_DIV - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          bv_q, bv_d;
    logic          fe_q, fe_d;
    logic [7:0]    byte_q, byte_d;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        bv_d    = 1'b0;
        fe_d    = 1'b0;
        byte_d  = byte_q;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            default: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        bv_d   = 1'b1;
                        byte_d = shreg_q;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            bv_q    <= 1'b0;
            fe_q    <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            bv_q    <= bv_d;
            fe_q    <= fe_d;
            byte_q  <= byte_d;
        end
    end

    assign byte_valid_o = bv_q;
    assign byte_data_o  = byte_q;
    assign frame_err_o  = fe_q;
    assign dbg_state_o  = state_q;

endmodule

// File: rtl/uart_inst_loader.sv
// UART boot loader: parses HDR, LEN_L, LEN_H, then 4*N little-endian bytes,
// writes words to instruction RAM from address 0 and pulses cpu_start.
module uart_inst_loader
    import uart_inst_loader_pkg::*;
#(
    parameter int         BAUD_DIV = BAUD_DIV_DEF,
    parameter int         IADR_W   = IADR_W_DEF,
    parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              inst_we,
    output logic [IADR_W-1:0] inst_wadr,
    output logic [31:0]       inst_wdata,
    output logic              cpu_start,
    output logic              loading,
    output logic              err,
    output logic [2:0]        dbg_state_o,
    output logic [1:0]        dbg_rx_state_o
);

    localparam int unsigned DEPTH = 32'd1 << IADR_W;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        frame_err;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (rx),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .frame_err_o  (frame_err),
        .dbg_state_o  (dbg_rx_state_o)
    );

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [15:0]       left_q, left_d;
    logic [IADR_W-1:0] idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [IADR_W-1:0] wadr_q, wadr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              start_q, start_d;
    logic              loading_q, loading_d;
    logic              err_q, err_d;
    logic [15:0]       len_full;

    always_comb begin
        state_d   = state_q;
        len_lo_d  = len_lo_q;
        left_d    = left_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        word_d    = word_q;
        we_d      = 1'b0;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        start_d   = 1'b0;
        loading_d = loading_q;
        err_d     = err_q;
        len_full  = {byte_data, len_lo_q};
        case (state_q)
            ST_IDLE: begin
                if (byte_valid && byte_data == HDR_BYTE) begin
                    err_d     = 1'b0;
                    loading_d = 1'b1;
                    state_d   = ST_LEN0;
                end
            end
            ST_LEN0: begin
                if (byte_valid) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (byte_valid) begin
                    if (len_full == 16'd0) begin
                        state_d = ST_START;
                    end else if (32'(len_full) > DEPTH) begin
                        err_d     = 1'b1;
                        loading_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        left_d  = len_full;
                        idx_d   = '0;
                        lane_d  = 2'd0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                // Bytes shift in from the top so the first byte ends up in [7:0].
                if (byte_valid) begin
                    word_d = {byte_data, word_q[31:8]};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        wadr_d  = idx_q;
                        wdata_d = word_d;
                        idx_d   = IADR_W'(idx_q + 1'b1);
                        left_d  = left_q - 16'd1;
                        if (left_q == 16'd1) state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                start_d   = 1'b1;
                loading_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (frame_err && state_q != ST_START) begin
            err_d = 1'b1;
            if (state_q != ST_IDLE) begin
                loading_d = 1'b0;
                state_d   = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_lo_q  <= 8'h00;
            left_q    <= 16'd0;
            idx_q     <= '0;
            lane_q    <= 2'd0;
            word_q    <= 32'h0;
            we_q      <= 1'b0;
            wadr_q    <= '0;
            wdata_q   <= 32'h0;
            start_q   <= 1'b0;
            loading_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            left_q    <= left_d;
            idx_q     <= idx_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            we_q      <= we_d;
            wadr_q    <= wadr_d;
            wdata_q   <= wdata_d;
            start_q   <= start_d;
            loading_q <= loading_d;
            err_q     <= err_d;
        end
    end

    assign inst_we     = we_q;
    assign inst_wadr   = wadr_q;
    assign inst_wdata  = wdata_q;
    assign cpu_start   = start_q;
    assign loading     = loading_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
